pi_vc_sel_arb: RTL and testbench

// - Upstream select generator for the pi-switch output muxes; drives mux select ports (e.g. lr_s, u0u1_s).
// - Per virtual channel, round-robin arbitration among N candidate inputs.
// - Registers the winning index and holds it under downstream backpressure.
// - Returns a one-cycle take pulse to the winning requester.
// - One instance per mux group: N=6 for the left/right muxes, N=4 for the up (u0/u1) muxes.

---
 rtl/pi_vc_sel_arb.sv | 114 +++++++++++
 tb/tb_pi_vc_sel_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_vc_sel_arb.sv
// Per-VC round-robin select generator for the pi-switch output muxes.
// Optional per-input wait counters and max_wait output: define PI_ARB_WAIT_CNT_EN.
module pi_vc_sel_arb #(
    parameter int N     = 6,
    parameter int VC_W  = 2,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [VC_W-1:0][N-1:0]     req,
    input  logic [VC_W-1:0]            out_ready,
    output logic [VC_W-1:0][SEL_W-1:0] sel,
    output logic [VC_W-1:0]            sel_vld,
    output logic [VC_W-1:0][N-1:0]     take
`ifdef PI_ARB_WAIT_CNT_EN
    ,
    output logic [VC_W-1:0][7:0]       max_wait
`endif
);

    logic [VC_W-1:0][SEL_W-1:0] ptr;
    logic [VC_W-1:0]            take_v;
    logic [VC_W-1:0]            load_en;
    logic [VC_W-1:0][N-1:0]     req_m;
    logic [VC_W-1:0][2*N-1:0]   rot;
    logic [VC_W-1:0]            found;
    logic [VC_W-1:0][SEL_W-1:0] win;
    logic [VC_W-1:0][SEL_W:0]   idx;

    // The requester being taken this cycle is masked, so rotating the doubled
    // vector by ptr turns the circular scan into a plain lowest-bit search.
    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            take_v[v]  = sel_vld[v] & out_ready[v];
            load_en[v] = ~sel_vld[v] | out_ready[v];
            for (int i = 0; i < N; i++) begin
                take[v][i] = take_v[v] && (sel[v] == SEL_W'(i));
            end
            req_m[v] = req[v] & ~take[v];
            rot[v]   = {req_m[v], req_m[v]} >> ptr[v];
            found[v] = 1'b0;
            win[v]   = '0;
            idx[v]   = '0;
            for (int k = 0; k < N; k++) begin
                if (!found[v] && rot[v][k]) begin
                    found[v] = 1'b1;
                    idx[v]   = {1'b0, ptr[v]} + (SEL_W+1)'(k);
                    if (idx[v] >= (SEL_W+1)'(N)) begin
                        idx[v] = idx[v] - (SEL_W+1)'(N);
                    end
                    win[v] = idx[v][SEL_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel     <= '0;
            sel_vld <= '0;
            ptr     <= '0;
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                if (take_v[v]) begin
                    ptr[v] <= (sel[v] == SEL_W'(N-1)) ? '0 : sel[v] + SEL_W'(1);
                end
                // An empty result drops the grant but leaves the mux select parked.
                if (load_en[v]) begin
                    if (found[v]) begin
                        sel[v]     <= win[v];
                        sel_vld[v] <= 1'b1;
                    end else begin
                        sel_vld[v] <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef PI_ARB_WAIT_CNT_EN
    logic [VC_W-1:0][N-1:0][7:0] wait_cnt;
    logic [VC_W-1:0][7:0]        cur_max;

    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            cur_max[v] = '0;
            for (int i = 0; i < N; i++) begin
                if (wait_cnt[v][i] > cur_max[v]) begin
                    cur_max[v] = wait_cnt[v][i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            max_wait <= '0;
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                max_wait[v] <= cur_max[v];
                for (int i = 0; i < N; i++) begin
                    if (!req[v][i] || take[v][i]) begin
                        wait_cnt[v][i] <= '0;
                    end else if (wait_cnt[v][i] != 8'hFF) begin
                        wait_cnt[v][i] <= wait_cnt[v][i] + 8'd1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pi_vc_sel_arb.sv
// Self-checking bench for pi_vc_sel_arb: directed scenarios plus randomized traffic
// against a queue-free integer reference model of the round-robin rules.
module tb_pi_vc_sel_arb;

    localparam int N     = 6;
    localparam int VC_W  = 2;
    localparam int SEL_W = $clog2(N);

    logic                       clk = 1'b0;
    logic                       rst;
    logic [VC_W-1:0][N-1:0]     req;
    logic [VC_W-1:0]            out_ready;
    logic [VC_W-1:0][SEL_W-1:0] sel;
    logic [VC_W-1:0]            sel_vld;
    logic [VC_W-1:0][N-1:0]     take;
`ifdef PI_ARB_WAIT_CNT_EN
    logic [VC_W-1:0][7:0]       max_wait;
`endif

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  done     = 1'b0;

    pi_vc_sel_arb #(.N(N), .VC_W(VC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .sel_vld   (sel_vld),
        .take      (take)
`ifdef PI_ARB_WAIT_CNT_EN
        ,
        .max_wait  (max_wait)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: grant index, valid flag and rr pointer per VC as plain ints.
    int m_sel [VC_W];
    bit m_vld [VC_W];
    int m_ptr [VC_W];
`ifdef PI_ARB_WAIT_CNT_EN
    int m_cnt [VC_W][N];
    int m_max [VC_W];
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_W; v++) begin
                m_sel[v] = 0;
                m_vld[v] = 1'b0;
                m_ptr[v] = 0;
`ifdef PI_ARB_WAIT_CNT_EN
                m_max[v] = 0;
                for (int i = 0; i < N; i++) m_cnt[v][i] = 0;
`endif
            end
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                bit tk;
                int nptr;
                int w;
                int c;
                tk = m_vld[v] && out_ready[v];
`ifdef PI_ARB_WAIT_CNT_EN
                w = 0;
                for (int i = 0; i < N; i++) if (m_cnt[v][i] > w) w = m_cnt[v][i];
                m_max[v] = w;
                for (int i = 0; i < N; i++) begin
                    if (!req[v][i] || (tk && m_sel[v] == i)) m_cnt[v][i] = 0;
                    else if (m_cnt[v][i] < 255) m_cnt[v][i] = m_cnt[v][i] + 1;
                end
`endif
                nptr = tk ? (m_sel[v] + 1) % N : m_ptr[v];
                if (!m_vld[v] || out_ready[v]) begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        c = (m_ptr[v] + k) % N;
                        if (w < 0 && req[v][c] && !(tk && c == m_sel[v])) w = c;
                    end
                    if (w >= 0) begin
                        m_sel[v] = w;
                        m_vld[v] = 1'b1;
                    end else begin
                        m_vld[v] = 1'b0;
                    end
                end
                m_ptr[v] = nptr;
            end
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, compare DUT outputs with the model once inputs have settled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !done) begin
                for (int v = 0; v < VC_W; v++) begin
                    int exp_take;
                    exp_take = (m_vld[v] && out_ready[v]) ? (1 << m_sel[v]) : 0;
                    check_output($sformatf("cmp_sel_v%0d", v), int'(sel[v]), m_sel[v]);
                    check_output($sformatf("cmp_vld_v%0d", v), int'(sel_vld[v]), int'(m_vld[v]));
                    check_output($sformatf("cmp_take_v%0d", v), int'(take[v]), exp_take);
`ifdef PI_ARB_WAIT_CNT_EN
                    check_output($sformatf("cmp_maxw_v%0d", v), int'(max_wait[v]), m_max[v]);
`endif
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [N-1:0] r0, input logic [N-1:0] r1,
                                  input logic [VC_W-1:0] rdy);
        @(negedge clk);
        req[0]    = r0;
        req[1]    = r1;
        out_ready = rdy;
        #3;
    endtask

    // Asserts reset without waiting for a clock edge, then releases on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_output("rst_vld", int'(sel_vld), 0);
        check_output("rst_sel", int'(sel), 0);
`ifdef PI_ARB_WAIT_CNT_EN
        check_output("rst_maxw", int'(max_wait), 0);
`endif
        @(negedge clk);
        req       = '0;
        out_ready = '0;
        rst       = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r0, r1;
        logic [VC_W-1:0] rdy;
        int exp_seq[4];

        rst       = 1'b0;
        req       = '0;
        out_ready = '0;
        #1;
        do_reset();

        // Rotation with all six requesting on VC0; VC1 idle.
        apply_stimulus(6'b111111, 6'b0, 2'b11);
        check_output("rot_empty", int'(sel_vld[0]), 0);
        for (int k = 0; k <= 6; k++) begin
            apply_stimulus(6'b111111, 6'b0, 2'b11);
            check_output($sformatf("rot_sel_%0d", k), int'(sel[0]), k % 6);
            check_output($sformatf("rot_take_%0d", k), int'(take[0]), 1 << (k % 6));
            check_output($sformatf("rot_vc1_vld_%0d", k), int'(sel_vld[1]), 0);
            check_output($sformatf("rot_vc1_take_%0d", k), int'(take[1]), 0);
        end
        apply_stimulus(6'b111111, 6'b0, 2'b00);
        check_output("rot_next_sel", int'(sel[0]), 1);

        // Mid-stream reset; after release the lowest requester wins.
        do_reset();
        req[0]    = 6'b011010;
        out_ready = 2'b11;
        apply_stimulus(6'b011010, 6'b0, 2'b11);
        check_output("rst_first_sel", int'(sel[0]), 1);
        check_output("rst_first_vld", int'(sel_vld[0]), 1);

        // Backpressure holds the grant, release takes it and advances.
        do_reset();
        apply_stimulus(6'b000110, 6'b0, 2'b00);
        check_output("bp_empty", int'(sel_vld[0]), 0);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(6'b000110, 6'b0, 2'b00);
            check_output($sformatf("bp_hold_sel_%0d", k), int'(sel[0]), 1);
            check_output($sformatf("bp_hold_take_%0d", k), int'(take[0]), 0);
        end
        apply_stimulus(6'b000110, 6'b0, 2'b01);
        check_output("bp_release_take", int'(take[0]), 6'b000010);
        apply_stimulus(6'b000100, 6'b0, 2'b01);
        check_output("bp_next_sel", int'(sel[0]), 2);

        // Take input 4 so ptr lands on 5, then 5 and 0 compete across the wrap.
        do_reset();
        apply_stimulus(6'b010000, 6'b0, 2'b01);
        apply_stimulus(6'b010000, 6'b0, 2'b01);
        check_output("wrap_pre_sel", int'(sel[0]), 4);
        apply_stimulus(6'b100001, 6'b0, 2'b01);
        check_output("wrap_gap_vld", int'(sel_vld[0]), 0);
        apply_stimulus(6'b100001, 6'b0, 2'b01);
        check_output("wrap_sel5", int'(sel[0]), 5);
        apply_stimulus(6'b000001, 6'b0, 2'b01);
        check_output("wrap_sel0", int'(sel[0]), 0);
        check_output("wrap_take0", int'(take[0]), 1);

        // Lone requester is granted every other cycle.
        do_reset();
        apply_stimulus(6'b001000, 6'b0, 2'b01);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(6'b001000, 6'b0, 2'b01);
            check_output($sformatf("lone_vld_%0d", k), int'(sel_vld[0]), (k % 2 == 0) ? 1 : 0);
        end

        // VC0 stalled with changing requests while VC1 rotates.
        do_reset();
        exp_seq = '{0, 1, 3, 0};
        apply_stimulus(6'b000011, 6'b001011, 2'b10);
        for (int k = 0; k < 4; k++) begin
            r0 = (k % 2 == 0) ? 6'b000011 : 6'b111100;
            apply_stimulus(r0, 6'b001011, 2'b10);
            check_output($sformatf("ind_vc1_sel_%0d", k), int'(sel[1]), exp_seq[k]);
            check_output($sformatf("ind_vc0_sel_%0d", k), int'(sel[0]), 0);
            check_output($sformatf("ind_vc0_vld_%0d", k), int'(sel_vld[0]), 1);
            check_output($sformatf("ind_vc0_take_%0d", k), int'(take[0]), 0);
        end

`ifdef PI_ARB_WAIT_CNT_EN
        // Input 4 granted but stalled long enough to saturate its wait counter.
        do_reset();
        for (int k = 0; k < 301; k++) apply_stimulus(6'b010000, 6'b0, 2'b00);
        check_output("wait_sat", int'(max_wait[0]), 255);
        apply_stimulus(6'b010000, 6'b0, 2'b01);
        check_output("wait_take", int'(take[0]), 6'b010000);
        apply_stimulus(6'b0, 6'b0, 2'b01);
        apply_stimulus(6'b0, 6'b0, 2'b01);
        check_output("wait_clear", int'(max_wait[0]), 0);
`endif

        // Randomized traffic; the compare process does the checking.
        do_reset();
        r0 = '0;
        r1 = '0;
        for (int k = 0; k < 2000; k++) begin
            r0  = (r0 & N'($urandom)) | (N'($urandom) & N'($urandom));
            r1  = (r1 & N'($urandom)) | (N'($urandom) & N'($urandom));
            rdy[0] = ($urandom_range(0, 3) != 0);
            rdy[1] = ($urandom_range(0, 3) != 0);
            apply_stimulus(r0, r1, rdy);
            if (k == 1000) do_reset();
        end

        apply_stimulus(6'b0, 6'b0, 2'b00);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
